simple_inst_issue: RTL

//   Fetch/decode/issue front end feeding the register-file/ALU execute stage.
//   - Fetches 32-bit instruction words from instruction memory over a req/ack interface.
//   - Decodes rs1/rs2/rd/immflag and the immediate, including an optional extension word.
//   - Presents one decoded instruction at a time to execute over a valid/ready handshake.

---
 rtl/simple_inst_issue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/simple_inst_issue.sv
// simple_inst_issue: fetch/decode/issue front end ahead of execute.
// Define SIMPLE_ISSUE_PERF_EN to add the issue_count transfer counter.
module simple_inst_issue #(
  parameter int REG_WIDTH  = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [ADDR_WIDTH-1:0] inst_rs1,
  output logic [ADDR_WIDTH-1:0] inst_rs2,
  output logic [ADDR_WIDTH-1:0] inst_rd,
  output logic                  inst_immflag,
  output logic [REG_WIDTH-1:0]  imm_data,
  output logic                  halted
`ifdef SIMPLE_ISSUE_PERF_EN
  ,
  output logic [31:0]           issue_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_IMM,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  immflag_q, immflag_d;
  logic [REG_WIDTH-1:0]  imm_q, imm_d;
  logic                  halted_q, halted_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  is_halt;
  logic                  is_long;
  logic                  start_ok;
  logic                  xfer;

  assign is_halt  = (imem_rdata == 32'hFFFF_FFFF);
  assign is_long  = imem_rdata[15] & imem_rdata[16];
  assign start_ok = start &
                    ((state_q == S_IDLE) | (state_q == S_HALT));
  assign xfer     = (state_q == S_ISSUE) & issue_ready;

  // Next-state, pc and decoded-field update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    immflag_d = immflag_q;
    imm_d     = imm_q;
    halted_d  = halted_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          pc_d      = pc_q + PC_WIDTH'(1);
          rd_d      = imem_rdata[4:0];
          rs1_d     = imem_rdata[9:5];
          rs2_d     = imem_rdata[14:10];
          immflag_d = imem_rdata[15];
          imm_d     = '0;
          if (imem_rdata[15] & !imem_rdata[16])
            imm_d = {{(REG_WIDTH-15){imem_rdata[31]}},
                     imem_rdata[31:17]};
          if (is_halt) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (is_long) begin
            state_d = S_FETCH_IMM;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_FETCH_IMM: begin
        if (imem_ack) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          imm_d   = {{(REG_WIDTH-32){imem_rdata[31]}},
                     imem_rdata};
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          halted_d = 1'b0;
          pc_d     = start_pc;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer counter, restarted by every accepted start.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)  cnt_d = '0;
    else if (xfer) cnt_d = cnt_q + 32'd1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      immflag_q <= 1'b0;
      imm_q     <= '0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      immflag_q <= immflag_d;
      imm_q     <= imm_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
    end
  end

  assign imem_req     = (state_q == S_FETCH) |
                        (state_q == S_FETCH_IMM);
  assign imem_addr    = imem_req ? pc_q : '0;
  assign issue_valid  = (state_q == S_ISSUE);
  assign inst_rs1     = rs1_q;
  assign inst_rs2     = rs2_q;
  assign inst_rd      = rd_q;
  assign inst_immflag = immflag_q;
  assign imm_data     = imm_q;
  assign halted       = halted_q;

`ifdef SIMPLE_ISSUE_PERF_EN
  assign issue_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule
